// File: rtl/writeback_combine_if.sv
// Signal bundle between the memory stage, writeback_combine and its consumers.
// The slave modport is the writeback stage; master is the upstream/memory side.
interface writeback_combine_if #(
   parameter int NPORTS = 2
);
   logic                   halt;
   logic                   bubble_in;
   logic [NPORTS*5-1:0]    tgt_in;
   logic [4:0]             opcode;
   logic                   is_load;
   logic                   is_store;
   logic                   load_signed;
   logic [NPORTS*32-1:0]   alu_result;
   logic [31:0]            addr;
   logic [31:0]            mem_result;
   logic                   mem_valid;
   logic                   mem_hi_req;
   logic                   stall_out;
   logic [NPORTS*32-1:0]   result_out;
   logic [NPORTS-1:0]      wb_we_out;
   logic [NPORTS*5-1:0]    wb_tgt_out;
   logic [NPORTS*32-1:0]   wb_result_out;

   modport master (
      output halt, bubble_in, tgt_in, opcode, is_load, is_store, load_signed,
             alu_result, addr, mem_result, mem_valid,
      input  mem_hi_req, stall_out, result_out, wb_we_out, wb_tgt_out, wb_result_out
   );

   modport slave (
      input  halt, bubble_in, tgt_in, opcode, is_load, is_store, load_signed,
             alu_result, addr, mem_result, mem_valid,
      output mem_hi_req, stall_out, result_out, wb_we_out, wb_tgt_out, wb_result_out
   );
endinterface

// File: rtl/writeback_combine.sv
// Writeback stage: load extraction with a two-beat combiner for loads that
// cross a word boundary, feeding NPORTS registered register-file write ports.
module writeback_combine #(
   parameter int NPORTS   = 2,
   parameter int MISALIGN = 1
) (
   input logic                clk,
   input logic                rst,
   writeback_combine_if.slave bus
);

   typedef enum logic {IDLE, HI} state_t;

   state_t                 state, state_nx;
   logic [31:0]            lo_reg;
   logic                   lo_load;
   logic                   stall;
   logic [2:0]             size;
   logic [1:0]             off;
   logic                   split;
   logic [31:0]            beat_lo, beat_hi;
   logic [31:0]            shifted;
   logic [31:0]            load_data;
   logic [NPORTS-1:0]      we;
   logic [NPORTS*32-1:0]   result;
   logic [NPORTS-1:0]      wb_we;
   logic [NPORTS*5-1:0]    wb_tgt;
   logic [NPORTS*32-1:0]   wb_result;
   logic                   unused_addr;

   assign unused_addr = ^bus.addr[31:2];

   // Access size in bytes; 0 marks a non-load opcode, which yields zero data.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      size = 3'd0;
      if (bus.opcode >= 5'd3 && bus.opcode <= 5'd5)       size = 3'd4;
      else if (bus.opcode >= 5'd6 && bus.opcode <= 5'd8)  size = 3'd2;
      else if (bus.opcode >= 5'd9 && bus.opcode <= 5'd11) size = 3'd1;
   end

   always_comb begin
      off = bus.addr[1:0];
      if (MISALIGN == 0) begin
         if (size == 3'd4)      off = 2'd0;
         else if (size == 3'd2) off[0] = 1'b0;
      end
   end

   assign split = (MISALIGN != 0) && bus.is_load && !bus.bubble_in
                  && (({1'b0, off} + size) > 3'd4);

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      lo_load  = 1'b0;
      beat_lo  = bus.mem_result;
      beat_hi  = 32'h0;
      case (state)
         IDLE: begin
            if (bus.is_load && !bus.bubble_in) begin
               if (!bus.mem_valid) begin
                  stall = 1'b1;
               end else if (split) begin
                  stall    = 1'b1;
                  lo_load  = 1'b1;
                  state_nx = HI;
               end
            end
         end
         HI: begin
            beat_lo = lo_reg;
            beat_hi = bus.mem_result;
            if (bus.mem_valid) state_nx = IDLE;
            else               stall    = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign shifted = 32'({beat_hi, beat_lo} >> {off, 3'b000});

   always_comb begin
      case (size)
         3'd4:    load_data = shifted;
         3'd2:    load_data = {{16{bus.load_signed & shifted[15]}}, shifted[15:0]};
         3'd1:    load_data = {{24{bus.load_signed & shifted[7]}}, shifted[7:0]};
         default: load_data = 32'h0;
      endcase
   end

   // Port 0 is the only port that can carry load data or be suppressed by a store.
   always_comb begin
      result = bus.alu_result;
      if (bus.is_load) result[31:0] = load_data;
      we = '0;
      for (int i = 0; i < NPORTS; i++) begin
         we[i] = (bus.tgt_in[i*5 +: 5] != 5'd0) && (bus.opcode != 5'd12) && !bus.bubble_in;
      end
      if (bus.is_store) we[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lo_reg    <= 32'h0;
         wb_we     <= '0;
         wb_tgt    <= '0;
         wb_result <= '0;
      end else if (!bus.halt) begin
         state <= state_nx;
         if (lo_load) lo_reg <= bus.mem_result;
         if (stall) begin
            wb_we <= '0;
         end else begin
            wb_we     <= we;
            wb_tgt    <= bus.tgt_in;
            wb_result <= result;
         end
      end
   end

   assign bus.mem_hi_req    = (state == HI);
   assign bus.stall_out     = stall;
   assign bus.result_out    = result;
   assign bus.wb_we_out     = wb_we;
   assign bus.wb_tgt_out    = wb_tgt;
   assign bus.wb_result_out = wb_result;

endmodule
